clk_div_multi: RTL and testbench



---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 126 ++++++++++++
 rtl/clk_div_multi.sv | 58 +++++
 tb/tb_clk_div_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock/tick generator.
//   CNT_W_DEFAULT : default counter / divisor / high-time width
//   cnt_t         : counter word at the default width
//   SYS_CLK_HZ    : system clock frequency the divisors are relative to
//   ch_state_e    : per-channel run state
package clk_div_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;
    localparam int unsigned SYS_CLK_HZ    = 50_000_000;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, double-buffered divisor/high time,
// registered divided output and period-start tick.
//   clk, reset      : system clock, synchronous active-low reset
//   en              : run enable (level)
//   load            : strobe capturing div_in/hi_in
//   sync_start      : force a period restart (tie low when unused)
//   div_in, hi_in   : requested period and high time in clk cycles
//   clk_out, tick   : registered divided output and period-start pulse
//   busy            : an update is pending until the next wrap
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             sync_start,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] hi_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_a_q, div_a_d;
    logic [CNT_W-1:0] hi_a_q,  hi_a_d;
    logic [CNT_W-1:0] div_p_q, div_p_d;
    logic [CNT_W-1:0] hi_p_q,  hi_p_d;
    logic             pend_q,  pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;
    logic             wrap;

    // State and data registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            div_a_q   <= '0;
            hi_a_q    <= '0;
            div_p_q   <= '0;
            hi_p_q    <= '0;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_a_q   <= div_a_d;
            hi_a_q    <= hi_a_d;
            div_p_q   <= div_p_d;
            hi_p_q    <= hi_p_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state, counter and shadow-register update
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_a_d   = div_a_q;
        hi_a_d    = hi_a_q;
        div_p_d   = div_p_q;
        hi_p_d    = hi_p_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        wrap      = 1'b0;

        // div_a_q is never zero while running; the guard keeps the decrement safe
        if (state_q == RUN && div_a_q != '0) begin
            wrap = (count_q == div_a_q - CNT_W'(1));
        end

        if (!en || state_q == IDLE) begin
            // Idle: outputs low, updates land in the active set immediately
            count_d = '0;
            if (pend_q) begin
                div_a_d = div_p_q;
                hi_a_d  = hi_p_q;
            end
            if (load) begin
                div_a_d = div_in;
                hi_a_d  = hi_in;
            end
            pend_d  = 1'b0;
            state_d = (en && div_a_d != '0) ? RUN : IDLE;
        end else begin
            tick_d    = (count_q == '0);
            clk_out_d = (count_q < hi_a_q);
            if (sync_start || wrap) begin
                // Period boundary: a same-edge load beats the older pending value
                count_d = '0;
                if (load) begin
                    div_a_d = div_in;
                    hi_a_d  = hi_in;
                end else if (pend_q) begin
                    div_a_d = div_p_q;
                    hi_a_d  = hi_p_q;
                end
                pend_d = 1'b0;
                if (div_a_d == '0) begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
                if (load) begin
                    div_p_d = div_in;
                    hi_p_d  = hi_in;
                    pend_d  = 1'b1;
                end
            end
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock/tick generator: NUM_CH independent runtime-programmable
// dividers of the system clock with glitch-free, period-aligned rate updates.
// Optional feature macro: CLK_DIV_MULTI_SYNC_EN adds sync_start, which
// restarts all running channels together and applies their pending updates.
//   clk, reset         : system clock, synchronous active-low reset
//   en, load           : per-channel enable level / update strobe
//   divisor, high_cnt  : channel i at [i*CNT_W +: CNT_W]
//   clk_out, tick      : per-channel divided output / period-start pulse
//   busy               : per-channel pending update flag
//   sync_start         : (macro only) phase-align all running channels
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] divisor,
    input  logic [NUM_CH*CNT_W-1:0] high_cnt,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       busy
`ifdef CLK_DIV_MULTI_SYNC_EN
    ,
    input  logic                    sync_start
`endif
);

    logic sync_w;

`ifdef CLK_DIV_MULTI_SYNC_EN
    assign sync_w = sync_start;
`else
    assign sync_w = 1'b0;
`endif

    // One independent divider per channel
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .en         (en[i]),
            .load       (load[i]),
            .sync_start (sync_w),
            .div_in     (divisor[i*CNT_W +: CNT_W]),
            .hi_in      (high_cnt[i*CNT_W +: CNT_W]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] divisor;
    logic [NUM_CH*CNT_W-1:0] high_cnt;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       busy;
    logic                    sync_start;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .divisor    (divisor),
        .high_cnt   (high_cnt),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
`ifdef CLK_DIV_MULTI_SYNC_EN
        ,
        .sync_start (sync_start)
`endif
    );

    always #10 clk = ~clk;

    // Reference model: "phase" = cycles elapsed in the current period
    bit              m_run   [NUM_CH];
    longint unsigned m_phase [NUM_CH];
    longint unsigned m_div   [NUM_CH];
    longint unsigned m_hi    [NUM_CH];
    longint unsigned m_pdiv  [NUM_CH];
    longint unsigned m_phi   [NUM_CH];
    bit              m_pend  [NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_busy;

    int n_vec = 0;
    int n_bad = 0;

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            longint unsigned din, hin;
            bit period_end;
            din = longint'(divisor[c*CNT_W +: CNT_W]);
            hin = longint'(high_cnt[c*CNT_W +: CNT_W]);
            if (!reset) begin
                m_run[c] = 0; m_phase[c] = 0; m_div[c] = 0; m_hi[c] = 0;
                m_pdiv[c] = 0; m_phi[c] = 0; m_pend[c] = 0;
                e_clk[c] = 0; e_tick[c] = 0;
            end else if (!en[c] || !m_run[c]) begin
                e_clk[c] = 0; e_tick[c] = 0; m_phase[c] = 0;
                if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_hi[c] = m_phi[c]; end
                if (load[c]) begin m_div[c] = din; m_hi[c] = hin; end
                m_pend[c] = 0;
                m_run[c] = en[c] && (m_div[c] != 0);
            end else begin
                e_tick[c] = (m_phase[c] == 0);
                e_clk[c]  = (m_phase[c] < m_hi[c]);
                period_end = (m_phase[c] + 1 == m_div[c]) || sync_start;
                if (period_end) begin
                    m_phase[c] = 0;
                    if (load[c]) begin m_div[c] = din; m_hi[c] = hin; end
                    else if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_hi[c] = m_phi[c]; end
                    m_pend[c] = 0;
                    if (m_div[c] == 0) m_run[c] = 0;
                end else begin
                    m_phase[c] = m_phase[c] + 1;
                    if (load[c]) begin m_pdiv[c] = din; m_phi[c] = hin; m_pend[c] = 1; end
                end
            end
            e_busy[c] = m_pend[c];
        end
    endtask

    task automatic check_vec(input string name, input logic [NUM_CH-1:0] got,
                             input logic [NUM_CH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_vec("clk_out", clk_out, e_clk);
        check_vec("tick",    tick,    e_tick);
        check_vec("busy",    busy,    e_busy);
    endtask

    task automatic set_ch(input int c, input longint unsigned d, input longint unsigned h);
        divisor[c*CNT_W +: CNT_W]  = CNT_W'(d);
        high_cnt[c*CNT_W +: CNT_W] = CNT_W'(h);
    endtask

    // Advance until channel c's model phase reaches ph (bounded)
    task automatic wait_phase(input int c, input longint unsigned ph);
        int n;
        n = 0;
        while (m_phase[c] != ph && n < 64) begin
            cycle();
            n++;
        end
        if (m_phase[c] != ph) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_phase ch%0d: phase %0d never reached %0d", c, m_phase[c], ph);
        end
    endtask

    initial begin
        logic [3:0] pat_clk;
        logic [3:0] pat_tick;
        pat_clk  = 4'b0011;   // bit k = clk_out at period offset k for div=4, hi=2
        pat_tick = 4'b0001;
        reset = 1'b0; en = '0; load = '0; divisor = '0; high_cnt = '0; sync_start = 1'b0;

        repeat (3) cycle();
        check_vec("reset_clk_out", clk_out, 4'b0000);
        check_vec("reset_tick",    tick,    4'b0000);
        check_vec("reset_busy",    busy,    4'b0000);

        // ch0: div=4 hi=2 loaded while idle, then enabled
        reset = 1'b1;
        set_ch(0, 4, 2); load[0] = 1'b1;
        cycle();
        load = '0; en[0] = 1'b1;
        cycle();
        check_bit("ch0_first_edge_clk", clk_out[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_bit("ch0_div4_clk",  clk_out[0], pat_clk[k % 4]);
            check_bit("ch0_div4_tick", tick[0],    pat_tick[k % 4]);
        end

        // ch1 div=1 hi=1, ch2 div=5 hi=0, ch3 div=5 hi=9
        set_ch(1, 1, 1); set_ch(2, 5, 0); set_ch(3, 5, 9);
        load[3:1] = 3'b111; en[3:1] = 3'b111;
        cycle();
        load = '0;
        repeat (2) cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_bit("ch1_div1_clk",  clk_out[1], 1'b1);
            check_bit("ch1_div1_tick", tick[1],    1'b1);
            check_bit("ch2_hi0_clk",   clk_out[2], 1'b0);
            check_bit("ch3_hi9_clk",   clk_out[3], 1'b1);
        end

        // ch0 to div=10, then load div=3 at count 4 of a 10-cycle period
        set_ch(0, 10, 5); load[0] = 1'b1;
        cycle();
        load = '0;
        wait_phase(0, 0);
        wait_phase(0, 4);
        set_ch(0, 3, 1); load[0] = 1'b1;
        cycle();
        load = '0;
        check_bit("ch0_busy_after_load", busy[0], 1'b1);
        wait_phase(0, 0);
        check_bit("ch0_busy_cleared", busy[0], 1'b0);
        repeat (7) cycle();

        // load coincident with the wrap edge
        wait_phase(0, 2);
        set_ch(0, 6, 3); load[0] = 1'b1;
        cycle();
        load = '0;
        check_bit("ch0_wrap_load_busy", busy[0], 1'b0);
        cycle();
        check_bit("ch0_wrap_load_tick", tick[0], 1'b1);
        repeat (12) cycle();

        // reset mid-period with an update pending
        wait_phase(0, 2);
        set_ch(0, 2, 1); load[0] = 1'b1;
        cycle();
        load = '0;
        check_bit("ch0_pending_before_reset", busy[0], 1'b1);
        reset = 1'b0;
        cycle();
        check_vec("midreset_clk_out", clk_out, 4'b0000);
        check_vec("midreset_busy",    busy,    4'b0000);
        reset = 1'b1;
        repeat (3) cycle();
        check_bit("ch0_idle_after_reset", clk_out[0], 1'b0);

`ifdef CLK_DIV_MULTI_SYNC_EN
        // misaligned ch0 div=4 and ch1 div=8, then sync_start
        en = '0;
        set_ch(0, 4, 2); load[0] = 1'b1; en[0] = 1'b1;
        cycle();
        load = '0;
        repeat (3) cycle();
        set_ch(1, 8, 4); load[1] = 1'b1; en[1] = 1'b1;
        cycle();
        load = '0;
        repeat (5) cycle();
        sync_start = 1'b1;
        cycle();
        sync_start = 1'b0;
        cycle();
        check_bit("sync_tick_ch0", tick[0], 1'b1);
        check_bit("sync_tick_ch1", tick[1], 1'b1);
        repeat (4) cycle();
`endif

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(0, 7) == 0);
                if (load[c]) set_ch(c, $urandom_range(0, 9), $urandom_range(0, 11));
            end
`ifdef CLK_DIV_MULTI_SYNC_EN
            sync_start = ($urandom_range(0, 49) == 0);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
